// File: rtl/uart_rx_deser.sv
// 8N1/8E1 UART receive deframer with input synchronizer and per-frame divider latch.
// Define UART_RX_PARITY_EN to add the even-parity bit (11-bit frame).
module uart_rx_deser #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_err_o,
  output logic             rx_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       div_min;
  logic [DIV_W-1:0]       mid_pt;
  logic [DIV_W-1:0]       end_pt;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q, par_err_d;
`endif

  // Synchronizer resets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign div_min = (clk_div_i < DIV_W'(2)) ? DIV_W'(2) : clk_div_i;
  assign mid_pt  = (div_q >> 1) - DIV_W'(1);
  assign end_pt  = div_q - DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_W'(1);
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    armed_d   = 1'b0;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      // armed_q remembers that rx_s was high last cycle while idle;
      // it is cleared in every busy state so a held-low line cannot retrigger.
      S_IDLE: begin
        cnt_d   = '0;
        armed_d = rx_s;
        if (armed_q && !rx_s) begin
          state_d = S_START;
          div_d   = div_min;
        end
      end
      S_START: begin
        if (cnt_q == mid_pt) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == end_pt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == end_pt) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == end_pt) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
          err_d   = par_err_q | ~rx_s;
`else
          err_d   = ~rx_s;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;
  assign rx_busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames are generated from bit lists and a
// queue model predicts each byte, its error flag and its pulse cycle.
module tb_uart_rx_deser;

  localparam int DIV_W = 32;
  localparam int SYNC  = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic [DIV_W-1:0] clk_div_i;
  logic             rx_i;
  logic [7:0]       rx_data_o;
  logic             rx_valid_o;
  logic             rx_err_o;
  logic             rx_busy_o;

  always #5 clk = ~clk;

  uart_rx_deser #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .clk_div_i (clk_div_i),
    .rx_i      (rx_i),
    .rx_data_o (rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_err_o  (rx_err_o),
    .rx_busy_o (rx_busy_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         t;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  int         npulses = 0;
  logic [7:0] hold_d = 8'h00;
  logic       hold_e = 1'b0;
  logic [7:0] last_d = 8'h00;
  logic       last_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Per-cycle compare against the queue model.
  always @(negedge clk) begin
    exp_t ent;
    if (rst_i) begin
      hold_d = 8'h00;
      hold_e = 1'b0;
      q.delete();
    end else if (rx_valid_o === 1'b1) begin
      npulses++;
      last_d = rx_data_o;
      last_e = rx_err_o;
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(q.size()), 32'd1);
      end else begin
        ent = q.pop_front();
        chk("data", 32'(rx_data_o), 32'(ent.d));
        chk("err", 32'(rx_err_o), 32'(ent.e));
        chk("latency", 32'(cyc), 32'(ent.t));
        chk("busy_at_valid", 32'(rx_busy_o), 32'd0);
        hold_d = ent.d;
        hold_e = ent.e;
      end
    end else begin
      chk("valid_low", 32'(rx_valid_o), 32'd0);
      chk("data_hold", 32'(rx_data_o), 32'(hold_d));
      chk("err_hold", 32'(rx_err_o), 32'(hold_e));
      if (q.size() > 0 && cyc > q[0].t) begin
        chk("pulse_timeout", 32'(rx_valid_o), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  // Call at #1 after a posedge. Drives nbits_drive bits of one frame at pdiv
  // clocks per bit; a complete frame queues its predicted result.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int pdiv, input int nbits_drive);
    logic [10:0] bits;
    exp_t        ent;
    int          c0;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ bad_par;
    bits[10] = ~bad_stop;
`else
    bits[9]  = ~bad_stop;
`endif
    c0 = cyc;
    if (nbits_drive >= NB) begin
      ent.d = d;
`ifdef UART_RX_PARITY_EN
      ent.e = ((^d) ^ bits[9]) | ~bits[10];
`else
      ent.e = ~bits[9];
`endif
      // Pulse follows the pin's mid-stop point by SYNC+1 cycles.
      ent.t = c0 + (NB - 1) * pdiv + pdiv / 2 + SYNC + 1;
      q.push_back(ent);
    end
    for (int i = 0; i < nbits_drive; i++) begin
      rx_i = bits[i];
      repeat (pdiv) @(posedge clk);
      #1;
    end
    if (nbits_drive >= NB) rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int   p0;
    int   c0;
    exp_t ent;
    rst_i     = 1'b1;
    rx_i      = 1'b1;
    clk_div_i = 16;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_data", 32'(rx_data_o), 32'h00);
    chk("reset_valid", 32'(rx_valid_o), 32'd0);
    chk("reset_err", 32'(rx_err_o), 32'd0);
    chk("reset_busy", 32'(rx_busy_o), 32'd0);
    @(posedge clk);
    #1;
    idle(4);

    // 1: clean 0xA5; divider input changes mid-frame and must be ignored
    p0 = npulses;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 16, NB);
      begin
        repeat (40) @(posedge clk);
        clk_div_i = 7;
      end
    join
    clk_div_i = 16;
    idle(20);
    chk("t1_count", 32'(npulses - p0), 32'd1);
    chk("t1_data", 32'(last_d), 32'hA5);
    chk("t1_err", 32'(last_e), 32'd0);

    // 2: erroneous frame (wrong parity, or bad stop without parity)
    p0 = npulses;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 16, NB);
`else
    send_frame(8'h01, 1'b0, 1'b1, 16, NB);
`endif
    idle(32);
    chk("t2_count", 32'(npulses - p0), 32'd1);
    chk("t2_data", 32'(last_d), 32'h01);
    chk("t2_err", 32'(last_e), 32'd1);

    // 3: 5-clock glitch is rejected at mid-start
    p0 = npulses;
    c0 = cyc;
    rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_mid", 32'(rx_busy_o), 32'd1);
    chk("t3_cycle", 32'(cyc - c0), 32'(16 / 2 + SYNC));
    @(posedge clk);
    @(negedge clk);
    chk("t3_busy_drop", 32'(rx_busy_o), 32'd0);
    @(posedge clk);
    #1;
    idle(40);
    chk("t3_count", 32'(npulses - p0), 32'd0);

    // 4: four back-to-back frames at div 10
    clk_div_i = 10;
    p0 = npulses;
    for (int i = 0; i < 4; i++) send_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 10, NB);
    idle(20);
    chk("t4_count", 32'(npulses - p0), 32'd4);
    chk("t4_last", 32'(last_d), 32'h44);
    chk("t4_err", 32'(last_e), 32'd0);

    // 5: break of 30 bit times yields exactly one 0x00 error byte
    clk_div_i = 16;
    p0 = npulses;
    c0 = cyc;
    ent.d = 8'h00;
    ent.e = 1'b1;
    ent.t = c0 + (NB - 1) * 16 + 8 + SYNC + 1;
    q.push_back(ent);
    rx_i = 1'b0;
    repeat (30 * 16) @(posedge clk);
    #1;
    chk("t5_count", 32'(npulses - p0), 32'd1);
    chk("t5_data", 32'(last_d), 32'h00);
    chk("t5_err", 32'(last_e), 32'd1);
    chk("t5_busy", 32'(rx_busy_o), 32'd0);
    idle(32);
    send_frame(8'h3C, 1'b0, 1'b0, 16, NB);
    idle(20);
    chk("t5_recover_count", 32'(npulses - p0), 32'd2);
    chk("t5_recover_data", 32'(last_d), 32'h3C);

    // 6: reset during DATA idx 4 aborts the frame, then 0x5A is received
    p0 = npulses;
    send_frame(8'h0F, 1'b0, 1'b0, 16, 5);
    chk("t6_busy_pre", 32'(rx_busy_o), 32'd1);
    rx_i  = 1'b1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("t6_rst_data", 32'(rx_data_o), 32'h00);
    chk("t6_rst_busy", 32'(rx_busy_o), 32'd0);
    @(posedge clk);
    #1;
    idle(40);
    chk("t6_abort_count", 32'(npulses - p0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 16, NB);
    idle(20);
    chk("t6_count", 32'(npulses - p0), 32'd1);
    chk("t6_data", 32'(last_d), 32'h5A);
    chk("t6_err", 32'(last_e), 32'd0);

    // 7: divider below 2 is clamped to 2
    p0 = npulses;
    clk_div_i = 1;
    send_frame(8'hC3, 1'b0, 1'b0, 2, NB);
    idle(20);
    clk_div_i = 0;
    send_frame(8'h96, 1'b0, 1'b0, 2, NB);
    idle(20);
    chk("t7_count", 32'(npulses - p0), 32'd2);
    chk("t7_data", 32'(last_d), 32'h96);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
